uart_apb_fifo_slave: RTL

//  APB3 completer fed directly by the APB BFM master's PSEL/PADDR/PENABLE/PWRITE/PWDATA outputs.
//  It returns PRDATA/PREADY/PSLVERR to that master.

---
 rtl/uart_apb_fifo_slave_if.sv | 26 ++
 rtl/uart_apb_fifo_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_fifo_slave_if.sv
// APB3 bus bundle between the BFM master and the UART FIFO completer.
// Handshake: the master raises PSEL with PENABLE low for one setup cycle, then
// holds PSEL, PENABLE, PADDR, PWRITE and PWDATA stable through the access
// phase. The transfer completes on the first rising edge where
// PSEL & PENABLE & PREADY are all high. PRDATA and PSLVERR are only meaningful
// while PREADY is high and read as 0 otherwise.
interface uart_apb_fifo_slave_if;
  logic        PSEL;
  logic [4:0]  PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_fifo_slave.sv
// APB3 completer bridging register accesses to byte-stream TX/RX FIFOs.
// Programmable wait states; illegal accesses complete with PSLVERR.
// Optional feature macro: UART_APB_FIFO_IRQ_EN adds IRQSTAT event flags,
// CTRL interrupt enables and a registered IRQ output.
module uart_apb_fifo_slave #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  uart_apb_fifo_slave_if.slave  apb,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  IRQ,
  output logic                  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    WS       = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       pready;

  // Decode of the current bus cycle
  logic [2:0] idx;
  logic       wr, complete, err;
  logic [31:0] rdata;

  // FIFO storage and pointers
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic [8:0]  tx_cnt9, rx_cnt9;
  logic [31:0] status;
  logic [1:0]  ctrl_en, irq_evt;
  logic        unused_bits;

  assign idx      = apb.PADDR[4:2];
  assign wr       = apb.PWRITE;
  assign complete = apb.PSEL & apb.PENABLE & pready;
  assign unused_bits = ^{apb.PWDATA[31:8], apb.PADDR[1:0]};

  // FSM state register and wait-state counter
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // FSM next state: setup enters ACCESS, completion or PSEL drop returns to IDLE
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_d = S_ACCESS;
          wait_d  = '0;
        end
      end
      S_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = S_IDLE;
        end else if (pready) begin
          if (apb.PENABLE) state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready once the programmed wait states have elapsed
  always_comb begin
    pready    = (state_q == S_ACCESS) && (wait_q == WS);
    dbg_state = state_q;
  end

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // Full/empty decisions use pre-edge state, so an APB push on a full FIFO
  // errors even if the stream side pops on the same edge (and vice versa).
  assign tx_push  = complete & wr & (idx == 3'd0) & ~tx_full;
  assign tx_pop   = ~tx_empty & TX_READY;
  assign tx_flush = complete & wr & (idx == 3'd3) & apb.PWDATA[0];
  assign rx_push  = RX_VALID & ~rx_full;
  assign rx_pop   = complete & ~wr & (idx == 3'd1) & ~rx_empty;
  assign rx_flush = complete & wr & (idx == 3'd3) & apb.PWDATA[1];

  assign TX_DATA  = tx_mem_q[tx_rd_q];
  assign TX_VALID = ~tx_empty;
  assign RX_READY = ~rx_full;

  assign tx_cnt9 = 9'(tx_cnt_q);
  assign rx_cnt9 = 9'(rx_cnt_q);
  assign status  = {6'b0, rx_cnt9, tx_cnt9, 4'b0, rx_empty, rx_full, tx_empty, tx_full};

  // TX FIFO next state; a flush wins over a same-edge stream pop
  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wr_q] = apb.PWDATA[7:0];
        tx_wr_d = tx_wr_q + AW'(1);
      end
      if (tx_pop) tx_rd_d = tx_rd_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // RX FIFO next state; a flush wins over a same-edge stream push
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wr_q] = RX_DATA;
        rx_wr_d = rx_wr_q + AW'(1);
      end
      if (rx_pop) rx_rd_d = rx_rd_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // FIFO state registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_mem_q <= tx_mem_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_mem_q <= rx_mem_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

`ifdef UART_APB_FIFO_IRQ_EN
  logic [1:0] ctrl_en_q, ctrl_en_d;
  logic [1:0] evt_q, evt_d;
  logic       irq_q, irq_d;

  // Interrupt enables, sticky events (set beats same-edge W1C) and IRQ
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    evt_d     = evt_q;
    if (complete && wr && (idx == 3'd3)) ctrl_en_d = apb.PWDATA[3:2];
    if (complete && wr && (idx == 3'd4)) evt_d = evt_q & ~apb.PWDATA[1:0];
    if (tx_pop && !tx_push && !tx_flush && (tx_cnt_q == CW'(1))) evt_d[0] = 1'b1;
    if (RX_VALID && rx_full) evt_d[1] = 1'b1;
    irq_d = (evt_q[0] & ctrl_en_q[0]) | (evt_q[1] & ctrl_en_q[1]) |
            (~rx_empty & ctrl_en_q[1]);
  end

  // Interrupt state registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_en_q <= '0;
      evt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      evt_q     <= evt_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_en = ctrl_en_q;
  assign irq_evt = evt_q;
  assign IRQ     = irq_q;
`else
  assign ctrl_en = 2'b00;
  assign irq_evt = 2'b00;
  assign IRQ     = 1'b0;
`endif

  // Register read mux and access legality
  always_comb begin
    err   = 1'b0;
    rdata = '0;
    case (idx)
      3'd0: err = ~wr | tx_full;
      3'd1: begin
        err   = wr | rx_empty;
        rdata = {24'b0, rx_mem_q[rx_rd_q]};
      end
      3'd2: begin
        err   = wr;
        rdata = status;
      end
      3'd3: rdata = {28'b0, ctrl_en, 2'b00};
      3'd4: rdata = {30'b0, irq_evt};
      default: err = 1'b1;
    endcase
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pready & err;
  assign apb.PRDATA  = (pready && !err && !wr) ? rdata : 32'h0;

endmodule
